// File: rtl/instr_encoder.sv
// instr_encoder: sequential MIPS program loader.
// Accepts instruction requests over valid/ready, packs them into 32-bit
// MIPS words and streams them into instruction memory through a stalling
// write port. One output entry is buffered; a new request can be accepted
// on the same edge the buffered word completes, giving one word per cycle.

module instr_encoder #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_kind,
  input  logic [4:0]            in_rs,
  input  logic [4:0]            in_rt,
  input  logic [4:0]            in_rd,
  input  logic [15:0]           in_imm,
  input  logic [25:0]           in_target,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wd,
  input  logic                  imem_ready,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  err,
  output logic                  full
);

  // Memory capacity in words; also the saturation point of count/issued.
  localparam logic [ADDR_WIDTH:0] CAP = {1'b1, {ADDR_WIDTH{1'b0}}};

  // Request kinds as presented on in_kind.
  localparam logic [3:0] K_ADD  = 4'd0;
  localparam logic [3:0] K_SUB  = 4'd1;
  localparam logic [3:0] K_AND  = 4'd2;
  localparam logic [3:0] K_OR   = 4'd3;
  localparam logic [3:0] K_SLT  = 4'd4;
  localparam logic [3:0] K_LW   = 4'd5;
  localparam logic [3:0] K_SW   = 4'd6;
  localparam logic [3:0] K_BEQ  = 4'd7;
  localparam logic [3:0] K_ADDI = 4'd8;
  localparam logic [3:0] K_J    = 4'd9;

  // Primary opcodes.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function codes.
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FULL = 2'd2
  } state_t;

  state_t                state_reg;
  logic [ADDR_WIDTH:0]   count_reg;
  logic [ADDR_WIDTH:0]   issued_reg;
  logic                  err_reg;
  logic                  we_reg;
  logic [31:0]           wd_reg;

  logic [31:0]           enc_word;
  logic                  enc_legal;
  logic                  accept;
  logic                  complete;
  logic [ADDR_WIDTH:0]   count_inc;

  // Combinational encoder: map the request fields onto a MIPS word.
  always_comb begin
    enc_word  = 32'd0;
    enc_legal = 1'b1;
    case (in_kind)
      K_ADD:  enc_word = {OP_RTYPE, in_rs, in_rt, in_rd, 5'd0, FN_ADD};
      K_SUB:  enc_word = {OP_RTYPE, in_rs, in_rt, in_rd, 5'd0, FN_SUB};
      K_AND:  enc_word = {OP_RTYPE, in_rs, in_rt, in_rd, 5'd0, FN_AND};
      K_OR:   enc_word = {OP_RTYPE, in_rs, in_rt, in_rd, 5'd0, FN_OR};
      K_SLT:  enc_word = {OP_RTYPE, in_rs, in_rt, in_rd, 5'd0, FN_SLT};
      K_LW:   enc_word = {OP_LW,   in_rs, in_rt, in_imm};
      K_SW:   enc_word = {OP_SW,   in_rs, in_rt, in_imm};
      K_BEQ:  enc_word = {OP_BEQ,  in_rs, in_rt, in_imm};
      K_ADDI: enc_word = {OP_ADDI, in_rs, in_rt, in_imm};
      K_J:    enc_word = {OP_J, in_target};
      default: enc_legal = 1'b0;
    endcase
  end

  // Handshake qualifiers. in_ready is combinational on start so that a
  // restart never races with an acceptance in the same cycle.
  always_comb begin
    in_ready  = (state_reg == S_RUN) && !start && (!we_reg || imem_ready) &&
                (issued_reg < CAP);
    accept    = in_valid && in_ready;
    complete  = we_reg && imem_ready;
    count_inc = (count_reg == CAP) ? count_reg : count_reg + 1'b1;
  end

  // Session FSM, output entry and counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= S_IDLE;
      count_reg  <= '0;
      issued_reg <= '0;
      err_reg    <= 1'b0;
      we_reg     <= 1'b0;
      wd_reg     <= 32'd0;
    end else if (start) begin
      // Restart at address 0; any pending write is abandoned.
      state_reg  <= S_RUN;
      count_reg  <= '0;
      issued_reg <= '0;
      err_reg    <= 1'b0;
      we_reg     <= 1'b0;
    end else begin
      if (complete) begin
        count_reg <= count_inc;
        if (state_reg == S_RUN && count_inc == CAP) begin
          state_reg <= S_FULL;
        end
      end
      if (accept && enc_legal) begin
        we_reg     <= 1'b1;
        wd_reg     <= enc_word;
        issued_reg <= issued_reg + 1'b1;
      end else begin
        if (accept) begin
          // Illegal kinds are consumed but produce no write.
          err_reg <= 1'b1;
        end
        if (complete) begin
          we_reg <= 1'b0;
        end
      end
    end
  end

  // Output mapping; the write address tracks the completed-word count.
  always_comb begin
    imem_we   = we_reg;
    imem_wd   = wd_reg;
    imem_addr = count_reg[ADDR_WIDTH-1:0];
    count     = count_reg;
    err       = err_reg;
    full      = (state_reg == S_FULL);
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: table-driven encodings, hand-written
// multi-cycle sequences and a randomized run against a behavioural model.

module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0, in_valid = 1'b0, imem_ready = 1'b0;
  logic        start2 = 1'b0, in_valid2 = 1'b0, imem_ready2 = 1'b0;
  logic [3:0]  in_kind = 4'd0;
  logic [4:0]  in_rs = 5'd0, in_rt = 5'd0, in_rd = 5'd0;
  logic [15:0] in_imm = 16'd0;
  logic [25:0] in_target = 26'd0;

  logic        in_ready, imem_we, err, full;
  logic [5:0]  imem_addr;
  logic [31:0] imem_wd;
  logic [6:0]  count;

  logic        in_ready2, imem_we2, err2, full2;
  logic [1:0]  imem_addr2;
  logic [31:0] imem_wd2;
  logic [2:0]  count2;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_WIDTH(6)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt),
    .in_rd(in_rd), .in_imm(in_imm), .in_target(in_target),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wd(imem_wd),
    .imem_ready(imem_ready), .count(count), .err(err), .full(full)
  );

  instr_encoder #(.ADDR_WIDTH(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .in_valid(in_valid2),
    .in_ready(in_ready2), .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt),
    .in_rd(in_rd), .in_imm(in_imm), .in_target(in_target),
    .imem_we(imem_we2), .imem_addr(imem_addr2), .imem_wd(imem_wd2),
    .imem_ready(imem_ready2), .count(count2), .err(err2), .full(full2)
  );

  // Reference encoding from field positions and opcode/funct values.
  function automatic logic [31:0] encode(input logic [3:0] kind, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [15:0] imm, input logic [25:0] tgt);
    int unsigned funct_tab[5] = '{32, 34, 36, 37, 42};
    int unsigned op_tab[4]    = '{35, 43, 4, 8};
    longint unsigned w;
    w = 0;
    if (kind <= 4)
      w = rs * (2**21) + rt * (2**16) + rd * (2**11) + funct_tab[kind];
    else if (kind <= 8)
      w = op_tab[kind - 5] * (2**26) + rs * (2**21) + rt * (2**16) + imm;
    else if (kind == 9)
      w = 2 * (2**26) + tgt;
    return w[31:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
    in_kind = k; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm; in_target = tgt;
  endtask

  typedef struct {
    logic [3:0]  kind;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic [31:0] word;
    logic [5:0]  addr;
  } vec_t;

  vec_t vecs[6];

  // Behavioural model state for the randomized run.
  bit          m_pend, m_err, m_full, exp_ready, comp, acc;
  int          m_cnt, m_iss;
  logic [31:0] m_word, w_exp;

  initial begin
    // Unused fields carry junk to show they are ignored.
    vecs[0] = '{4'd0, 5'd1,  5'd2,  5'd3,  16'hFFFF, 26'h3FFFFFF, 32'h00221820, 6'd0};
    vecs[1] = '{4'd5, 5'd0,  5'd8,  5'd31, 16'h0004, 26'h1234567, 32'h8C080004, 6'd1};
    vecs[2] = '{4'd6, 5'd29, 5'd31, 5'd7,  16'hFFFC, 26'h0000001, 32'hAFBFFFFC, 6'd2};
    vecs[3] = '{4'd7, 5'd4,  5'd5,  5'd9,  16'hFFFF, 26'h2AAAAAA, 32'h1085FFFF, 6'd3};
    vecs[4] = '{4'd8, 5'd0,  5'd2,  5'd1,  16'h0005, 26'h0000000, 32'h20020005, 6'd4};
    vecs[5] = '{4'd9, 5'd17, 5'd18, 5'd19, 16'hBEEF, 26'h0000010, 32'h08000010, 6'd5};

    // ---------------- reset ----------------
    #1 reset_n = 1'b0;
    #3;
    check("rst_we", imem_we, 0);
    check("rst_count", count, 0);
    @(negedge clk) reset_n = 1'b1;
    @(negedge clk);
    check("rst_ready", in_ready, 0);
    check("rst_we2", imem_we, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_wd", imem_wd, 0);
    check("rst_err", err, 0);
    check("rst_full", full, 0);

    // ---------------- start ----------------
    tick();
    start = 1'b1;
    @(negedge clk);
    check("start_ready_low", in_ready, 0);
    tick();
    start = 1'b0;
    imem_ready = 1'b1;
    @(negedge clk);
    check("start_ready", in_ready, 1);
    check("start_addr", imem_addr, 0);

    // ---------------- table of legal encodings ----------------
    tick();
    for (int i = 0; i <= 6; i++) begin
      if (i < 6) begin
        set_req(vecs[i].kind, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].imm, vecs[i].tgt);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (i > 0) begin
        $display("vec %0d: addr=%0d wd=0x%08h", i - 1, imem_addr, imem_wd);
        check("vec_we", imem_we, 1);
        check("vec_addr", imem_addr, vecs[i-1].addr);
        check("vec_wd", imem_wd, vecs[i-1].word);
      end
      if (i < 6) check("vec_ready", in_ready, 1);
      tick();
    end
    @(negedge clk);
    check("vec_count", count, 6);
    check("vec_idle_we", imem_we, 0);

    // ---------------- backpressure ----------------
    tick();
    set_req(4'd0, 5'd1, 5'd1, 5'd1, 16'd0, 26'd0);
    w_exp = encode(4'd0, 5'd1, 5'd1, 5'd1, 16'd0, 26'd0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    imem_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      $display("stall %0d: we=%0d addr=%0d wd=0x%08h", c, imem_we, imem_addr, imem_wd);
      check("bp_we", imem_we, 1);
      check("bp_addr", imem_addr, 6);
      check("bp_wd", imem_wd, w_exp);
      check("bp_ready", in_ready, 0);
      check("bp_count", count, 6);
      tick();
    end
    imem_ready = 1'b1;
    tick();
    @(negedge clk);
    check("bp_done_count", count, 7);
    check("bp_done_we", imem_we, 0);

    // ---------------- illegal kind ----------------
    tick();
    set_req(4'hF, 5'd1, 5'd2, 5'd3, 16'h1234, 26'd5);
    in_valid = 1'b1;
    @(negedge clk);
    check("ill_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    $display("illegal: err=%0d we=%0d count=%0d", err, imem_we, count);
    check("ill_err", err, 1);
    check("ill_we", imem_we, 0);
    check("ill_count", count, 7);
    tick();
    set_req(4'd0, 5'd2, 5'd3, 5'd4, 16'd0, 26'd0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("ill_next_we", imem_we, 1);
    check("ill_next_addr", imem_addr, 7);
    check("ill_next_wd", imem_wd, encode(4'd0, 5'd2, 5'd3, 5'd4, 16'd0, 26'd0));
    check("ill_err_sticky", err, 1);
    tick();
    @(negedge clk);
    check("ill_next_count", count, 8);

    // ---------------- randomized run vs model ----------------
    tick();
    start = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    check("rnd_start_ready", in_ready, 0);
    tick();
    start = 1'b0;
    m_pend = 0; m_err = 0; m_full = 0; m_cnt = 0; m_iss = 0; m_word = 0;
    for (int c = 0; c < 400; c++) begin
      in_valid   = ($urandom_range(9, 0) < 7);
      imem_ready = ($urandom_range(9, 0) < 6);
      set_req(4'($urandom_range(11, 0)), 5'($urandom), 5'($urandom), 5'($urandom),
              16'($urandom), 26'($urandom));
      @(negedge clk);
      exp_ready = !m_full && (!m_pend || imem_ready) && (m_iss < 64);
      check("rnd_ready", in_ready, exp_ready);
      check("rnd_we", imem_we, m_pend);
      check("rnd_count", count, m_cnt);
      check("rnd_err", err, m_err);
      check("rnd_full", full, m_full);
      if (m_pend) begin
        check("rnd_addr", imem_addr, m_cnt % 64);
        check("rnd_wd", imem_wd, m_word);
      end
      comp = m_pend && imem_ready;
      acc  = in_valid && exp_ready;
      if (comp) begin
        $display("rnd write: addr=%0d wd=0x%08h", m_cnt % 64, m_word);
        m_cnt++;
        m_pend = 0;
        if (m_cnt == 64) m_full = 1;
      end
      if (acc) begin
        if (in_kind <= 9) begin
          m_pend = 1;
          m_word = encode(in_kind, in_rs, in_rt, in_rd, in_imm, in_target);
          m_iss++;
        end else begin
          m_err = 1;
        end
      end
      tick();
    end
    in_valid = 1'b0;

    // ---------------- ADDR_WIDTH=2 fill and restart ----------------
    start2 = 1'b1;
    imem_ready2 = 1'b1;
    tick();
    start2 = 1'b0;
    set_req(4'hC, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
    in_valid2 = 1'b1;
    tick();
    set_req(4'd1, 5'd6, 5'd7, 5'd8, 16'd0, 26'd0);
    for (int c = 0; c < 4; c++) tick();
    in_valid2 = 1'b0;
    tick();
    @(negedge clk);
    $display("aw2 fill: count=%0d full=%0d ready=%0d err=%0d", count2, full2, in_ready2, err2);
    check("aw2_full", full2, 1);
    check("aw2_ready", in_ready2, 0);
    check("aw2_count", count2, 4);
    check("aw2_err", err2, 1);
    check("aw2_we", imem_we2, 0);
    tick();
    start2 = 1'b1;
    @(negedge clk);
    check("aw2_start_ready", in_ready2, 0);
    tick();
    start2 = 1'b0;
    @(negedge clk);
    check("aw2_rs_full", full2, 0);
    check("aw2_rs_count", count2, 0);
    check("aw2_rs_err", err2, 0);
    check("aw2_rs_addr", imem_addr2, 0);
    check("aw2_rs_ready", in_ready2, 1);
    tick();
    set_req(4'd6, 5'd3, 5'd4, 5'd0, 16'h0010, 26'd0);
    in_valid2 = 1'b1;
    tick();
    in_valid2 = 1'b0;
    @(negedge clk);
    check("aw2_new_we", imem_we2, 1);
    check("aw2_new_addr", imem_addr2, 0);
    check("aw2_new_wd", imem_wd2, encode(4'd6, 5'd3, 5'd4, 5'd0, 16'h0010, 26'd0));

    // ---------------- asynchronous reset mid-write ----------------
    tick();
    start = 1'b1;
    imem_ready = 1'b1;
    tick();
    start = 1'b0;
    set_req(4'd3, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0);
    in_valid = 1'b1;
    tick();
    tick();
    tick();
    in_valid = 1'b0;
    imem_ready = 1'b0;
    @(negedge clk);
    check("ar_pre_we", imem_we, 1);
    check("ar_pre_count", count, 2);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    $display("async reset: we=%0d count=%0d ready=%0d", imem_we, count, in_ready);
    check("ar_we", imem_we, 0);
    check("ar_count", count, 0);
    check("ar_ready", in_ready, 0);
    @(negedge clk) reset_n = 1'b1;
    in_valid = 1'b1;
    imem_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("ar_idle_ready", in_ready, 0);
      check("ar_idle_we", imem_we, 0);
      check("ar_idle_count", count, 0);
      tick();
    end
    in_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
